// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: MEMPREP + MEMEX load/store stages between EX and WB.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module lsu_mem_stage #(
  parameter int ADDR_W = 12,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [3:0]        in_rd,
  input  logic              in_we,
  input  logic [3:0]        in_mem_op,
  input  logic [XLEN-1:0]   in_addr,
  input  logic [XLEN-1:0]   in_store_data,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-3:0] dmem_addr,
  output logic [3:0]        dmem_wstrb,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_ready,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              out_valid,
  output logic [3:0]        out_rd,
  output logic [XLEN-1:0]   out_result,
  output logic              out_we,
  output logic              misalign
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef struct packed {
    logic            valid;
    logic [3:0]      rd;
    logic            we;
    logic            ld;
    logic            st;
    logic [1:0]      sz;
    logic            sext;
    logic            mis;
    logic [1:0]      off;
    logic [XLEN-1:0] addr;
    logic [3:0]      wstrb;
    logic [XLEN-1:0] wdata;
  } stage_t;

  stage_t          p_q, p_d, e_q, e_d;
  logic [1:0]      state_q, state_d;
  logic            o_valid_q, o_valid_d;
  logic            o_we_q, o_we_d;
  logic            mis_q, mis_d;
  logic [3:0]      o_rd_q, o_rd_d;
  logic [XLEN-1:0] o_res_q, o_res_d;

  logic            ld, st, sext;
  logic [1:0]      sz;
  logic [7:0]      lb;
  logic [15:0]     lh;
  logic [XLEN-1:0] ld_data;

  always_comb begin
    ld   = 1'b0;
    st   = 1'b0;
    sext = 1'b0;
    sz   = SZ_W;
    unique case (in_mem_op)
      4'd1:    begin ld = 1'b1; sz = SZ_B; sext = 1'b1; end
      4'd2:    begin ld = 1'b1; sz = SZ_H; sext = 1'b1; end
      4'd3:    ld = 1'b1;
      4'd4:    begin ld = 1'b1; sz = SZ_B; end
      4'd5:    begin ld = 1'b1; sz = SZ_H; end
      4'd9:    begin st = 1'b1; sz = SZ_B; end
      4'd10:   begin st = 1'b1; sz = SZ_H; end
      4'd11:   st = 1'b1;
      default: ;
    endcase
  end

  assign stall = (state_q != S_IDLE);

  always_comb begin
    p_d = p_q;
    if (!stall) begin
      p_d.valid = in_valid;
      p_d.rd    = in_rd;
      p_d.we    = in_we;
      p_d.ld    = in_valid & ld;
      p_d.st    = in_valid & st;
      p_d.sz    = sz;
      p_d.sext  = sext;
      p_d.addr  = in_addr;
`ifdef LSU_MISALIGN_TRAP_EN
      p_d.off   = in_addr[1:0];
      p_d.mis   = (ld | st) &
                  (((sz == SZ_H) & in_addr[0]) |
                   ((sz == SZ_W) & (in_addr[1:0] != 2'd0)));
`else
      // Without the trap, silently round down to natural alignment.
      p_d.mis   = 1'b0;
      p_d.off   = (sz == SZ_B) ? in_addr[1:0] :
                  (sz == SZ_H) ? {in_addr[1], 1'b0} : 2'd0;
`endif
      p_d.wstrb = 4'h0;
      if (ld | st) begin
        unique case (sz)
          SZ_B:    p_d.wstrb = 4'b0001 << p_d.off;
          SZ_H:    p_d.wstrb = 4'b0011 << p_d.off;
          default: p_d.wstrb = 4'hF;
        endcase
      end
      p_d.wdata = (sz == SZ_B) ? {4{in_store_data[7:0]}} :
                  (sz == SZ_H) ? {2{in_store_data[15:0]}} :
                  in_store_data;
    end
  end

  always_comb begin
    unique case (e_q.off)
      2'd0:    lb = dmem_rdata[7:0];
      2'd1:    lb = dmem_rdata[15:8];
      2'd2:    lb = dmem_rdata[23:16];
      default: lb = dmem_rdata[31:24];
    endcase
    lh = e_q.off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    unique case (e_q.sz)
      SZ_B:    ld_data = {{24{e_q.sext & lb[7]}}, lb};
      SZ_H:    ld_data = {{16{e_q.sext & lh[15]}}, lh};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    e_d       = e_q;
    o_valid_d = 1'b0;
    o_we_d    = 1'b0;
    mis_d     = 1'b0;
    o_rd_d    = o_rd_q;
    o_res_d   = o_res_q;
    unique case (state_q)
      S_IDLE: begin
        if (e_q.valid && !(e_q.ld || e_q.st) && e_q.we) begin
          o_valid_d = 1'b1;
          o_we_d    = 1'b1;
          o_rd_d    = e_q.rd;
          o_res_d   = e_q.addr;
        end
        if (e_q.mis) begin
          o_valid_d = 1'b1;
          o_rd_d    = e_q.rd;
          mis_d     = 1'b1;
        end
        e_d = p_q;
        if ((p_q.ld || p_q.st) && !p_q.mis)
          state_d = S_REQ;
      end
      S_REQ: begin
        if (dmem_ready) begin
          if (e_q.st) begin
            o_valid_d = 1'b1;
            o_rd_d    = e_q.rd;
            o_res_d   = '0;
            state_d   = S_IDLE;
          end else begin
            state_d   = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (dmem_rvalid) begin
          o_valid_d = 1'b1;
          o_we_d    = 1'b1;
          o_rd_d    = e_q.rd;
          o_res_d   = ld_data;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_q       <= '0;
      e_q       <= '0;
      state_q   <= S_IDLE;
      o_valid_q <= 1'b0;
      o_we_q    <= 1'b0;
      mis_q     <= 1'b0;
      o_rd_q    <= '0;
      o_res_q   <= '0;
    end else begin
      p_q       <= p_d;
      e_q       <= e_d;
      state_q   <= state_d;
      o_valid_q <= o_valid_d;
      o_we_q    <= o_we_d;
      mis_q     <= mis_d;
      o_rd_q    <= o_rd_d;
      o_res_q   <= o_res_d;
    end
  end

  assign dmem_req   = (state_q == S_REQ);
  assign dmem_we    = dmem_req & e_q.st;
  assign dmem_addr  = dmem_req ? e_q.addr[ADDR_W-1:2] : '0;
  assign dmem_wstrb = dmem_req ? e_q.wstrb : 4'h0;
  assign dmem_wdata = dmem_req ? e_q.wdata : '0;

  assign out_valid  = o_valid_q;
  assign out_we     = o_we_q;
  assign out_rd     = o_rd_q;
  assign out_result = o_res_q;
  assign misalign   = mis_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: scoreboard bench for lsu_mem_stage.
// Honours LSU_MISALIGN_TRAP_EN to select the misaligned-access expectation.
module tb_lsu_mem_stage;

  logic        clk, rst;
  logic        in_valid, in_we;
  logic [3:0]  in_rd, in_mem_op;
  logic [31:0] in_addr, in_store_data;
  logic        stall, dmem_req, dmem_we;
  logic [9:0]  dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_ready, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        out_valid, out_we, misalign;
  logic [3:0]  out_rd;
  logic [31:0] out_result;

  lsu_mem_stage #(.ADDR_W(12), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_rd(in_rd), .in_we(in_we),
    .in_mem_op(in_mem_op), .in_addr(in_addr),
    .in_store_data(in_store_data),
    .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .out_valid(out_valid), .out_rd(out_rd),
    .out_result(out_result), .out_we(out_we),
    .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rd;
    logic        we;
    logic [31:0] res;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   wb_cnt = 0;
  int   mis_cnt = 0;

  // memory responder state
  int          ready_dly = 0;
  int          rv_dly = 1;
  logic [31:0] rd_word = 32'h0;
  int          wcnt = 0;
  int          rv_cnt = 0;
  bit          rv_pend = 0;
  int          req_cnt = 0;
  int          req_seen = 0;
  logic [9:0]  lg_addr;
  logic        lg_we;
  logic [3:0]  lg_wstrb;
  logic [31:0] lg_wdata;

  always @(negedge clk) begin
    dmem_ready  = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h5A5A_5A5A;
    if (rv_pend) begin
      rv_cnt--;
      if (rv_cnt == 0) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = rd_word;
        rv_pend     = 0;
      end
    end
    if (!rst) begin
      wcnt = 0;
    end else if (dmem_req) begin
      req_seen++;
      if (wcnt == ready_dly) begin
        dmem_ready = 1'b1;
        wcnt       = 0;
        req_cnt++;
        lg_addr  = dmem_addr;
        lg_we    = dmem_we;
        lg_wstrb = dmem_wstrb;
        lg_wdata = dmem_wdata;
        if (!dmem_we) begin
          rv_pend = 1;
          rv_cnt  = rv_dly;
        end
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  // WB scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (misalign) mis_cnt++;
    if (out_valid) begin
      wb_cnt++;
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL wb_unexpected: got rd=%0d we=%b res=%h, none expected",
                 out_rd, out_we, out_result);
      end else begin
        e = sb.pop_front();
        if (out_rd !== e.rd || out_we !== e.we ||
            (e.we && out_result !== e.res)) begin
          n_err++;
          $display("FAIL wb_%s: got rd=%0d we=%b res=%h, want rd=%0d we=%b res=%h",
                   e.nm, out_rd, out_we, out_result, e.rd, e.we, e.res);
        end
      end
    end
  end

  task automatic drive(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] rd,
                       input logic we);
    bit done = 0;
    in_valid = 1'b1; in_mem_op = op; in_addr = a;
    in_store_data = d; in_rd = rd; in_we = we;
    for (int i = 0; i < 40 && !done; i++) begin
      done = !stall;
      @(negedge clk);
    end
    in_valid = 1'b0; in_mem_op = 4'd0;
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL drive_timeout: stall=%b, want 0", stall);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b0; in_we = 1'b0; in_rd = 4'd0; in_mem_op = 4'd0;
    in_addr = 32'h0; in_store_data = 32'h0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({out_valid, out_we, out_rd, out_result, misalign} !== '0) begin
      n_err++;
      $display("FAIL reset_wb: got v=%b we=%b rd=%0d res=%h mis=%b, want all 0",
               out_valid, out_we, out_rd, out_result, misalign);
    end
    n_cmp++;
    if ({stall, dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata} !== '0) begin
      n_err++;
      $display("FAIL reset_mem: got stall=%b req=%b we=%b a=%h s=%h d=%h, want all 0",
               stall, dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({stall, dmem_req, out_valid} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_idle: got stall=%b req=%b v=%b, want 000",
               stall, dmem_req, out_valid);
    end
  endtask

  task automatic test_passthru();
    int r0 = req_seen;
    sb.push_back('{4'd5, 1'b1, 32'h0000_1234, "passthru"});
    drive(4'd0, 32'h0000_1234, 32'h0, 4'd5, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL passthru_early: got out_valid=%b after 2 edges, want 0", out_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL passthru_latency: got out_valid=%b after 3 edges, want 1", out_valid);
    end
    wait_drain();
    n_cmp++;
    if (req_seen != r0) begin
      n_err++;
      $display("FAIL passthru_noreq: got %0d req cycles, want 0", req_seen - r0);
    end
  endtask

  task automatic test_bubble();
    int w0 = wb_cnt;
    drive(4'd0, 32'h55, 32'h0, 4'd6, 1'b0);
    in_valid = 1'b0; in_mem_op = 4'd11; in_we = 1'b1;
    repeat (6) @(negedge clk);
    in_mem_op = 4'd0;
    n_cmp++;
    if (wb_cnt != w0) begin
      n_err++;
      $display("FAIL bubble: got %0d WB outputs, want 0", wb_cnt - w0);
    end
  endtask

  task automatic test_stores();
    int c0 = req_cnt;
    ready_dly = 0;
    sb.push_back('{4'd7, 1'b0, 32'h0, "sb"});
    drive(4'd9, 32'h0000_0102, 32'h0000_00AB, 4'd7, 1'b0);
    wait_drain();
    n_cmp++;
    if (req_cnt != c0 + 1 || {lg_we, lg_addr, lg_wstrb, lg_wdata} !==
        {1'b1, 10'h040, 4'b0100, 32'hABAB_ABAB}) begin
      n_err++;
      $display("FAIL sb_req: got n=%0d we=%b a=%h s=%b d=%h, want n=1 we=1 a=040 s=0100 d=abababab",
               req_cnt - c0, lg_we, lg_addr, lg_wstrb, lg_wdata);
    end
    ready_dly = 1;
    sb.push_back('{4'd2, 1'b0, 32'h0, "sh"});
    drive(4'd10, 32'h0000_0106, 32'h1234_BEEF, 4'd2, 1'b0);
    wait_drain();
    n_cmp++;
    if ({lg_we, lg_addr, lg_wstrb, lg_wdata} !== {1'b1, 10'h041, 4'b1100, 32'hBEEF_BEEF}) begin
      n_err++;
      $display("FAIL sh_req: got we=%b a=%h s=%b d=%h, want we=1 a=041 s=1100 d=beefbeef",
               lg_we, lg_addr, lg_wstrb, lg_wdata);
    end
  endtask

  task automatic test_load_lb();
    int bad = 0;
    int waited = 0;
    ready_dly = 2; rv_dly = 1; rd_word = 32'h80FF_0000;
    sb.push_back('{4'd3, 1'b1, 32'hFFFF_FF80, "lb"});
    drive(4'd1, 32'h0000_0103, 32'h0, 4'd3, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 40 && !out_valid; i++) begin
      if (!stall) bad++;
      waited++;
      @(negedge clk);
    end
    n_cmp++;
    if (bad != 0 || waited < 4) begin
      n_err++;
      $display("FAIL lb_stall: got %0d unstalled of %0d wait cycles, want 0 of >=4",
               bad, waited);
    end
    n_cmp++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("FAIL lb_release: got stall=%b at WB, want 0", stall);
    end
    wait_drain();
  endtask

  task automatic test_load_misc();
    ready_dly = 1; rv_dly = 2; rd_word = 32'h8001_1234;
    sb.push_back('{4'd4, 1'b1, 32'h0000_8001, "lhu"});
    drive(4'd5, 32'h0000_0002, 32'h0, 4'd4, 1'b1);
    wait_drain();
    sb.push_back('{4'd4, 1'b1, 32'hFFFF_8001, "lh"});
    drive(4'd2, 32'h0000_0002, 32'h0, 4'd4, 1'b1);
    wait_drain();
    rd_word = 32'h0000_9A00;
    sb.push_back('{4'd1, 1'b1, 32'h0000_009A, "lbu"});
    drive(4'd4, 32'h0000_0001, 32'h0, 4'd1, 1'b1);
    wait_drain();
    rd_word = 32'h1234_5678;
    sb.push_back('{4'd11, 1'b1, 32'h1234_5678, "lw_hiaddr"});
    drive(4'd3, 32'hFFFF_F104, 32'h0, 4'd11, 1'b1);
    wait_drain();
    n_cmp++;
    if ({lg_we, lg_addr, lg_wstrb} !== {1'b0, 10'h041, 4'hF}) begin
      n_err++;
      $display("FAIL lw_hiaddr_req: got we=%b a=%h s=%h, want we=0 a=041 s=f",
               lg_we, lg_addr, lg_wstrb);
    end
  endtask

  task automatic test_back_to_back();
    ready_dly = 0; rv_dly = 1; rd_word = 32'hDEAD_BEEF;
    sb.push_back('{4'd1, 1'b1, 32'h0000_0011, "b2b_a"});
    sb.push_back('{4'd2, 1'b1, 32'h0000_0022, "b2b_b"});
    sb.push_back('{4'd3, 1'b1, 32'hDEAD_BEEF, "b2b_ld"});
    sb.push_back('{4'd9, 1'b1, 32'h0000_0033, "b2b_c"});
    drive(4'd0, 32'h11, 32'h0, 4'd1, 1'b1);
    drive(4'd0, 32'h22, 32'h0, 4'd2, 1'b1);
    drive(4'd3, 32'h08, 32'h0, 4'd3, 1'b1);
    drive(4'd0, 32'h33, 32'h0, 4'd9, 1'b1);
    wait_drain();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL b2b_drain: got %0d pending, want 0", sb.size());
    end
  endtask

  task automatic test_rst_mid();
    int c0 = req_cnt;
    int w0;
    bit hit = 0;
    ready_dly = 0; rv_dly = 4; rd_word = 32'h7777_7777;
    drive(4'd3, 32'h0000_0010, 32'h0, 4'd8, 1'b1);
    for (int i = 0; i < 20 && !hit; i++) begin
      hit = stall && !dmem_req && req_cnt == c0 + 1;
      if (!hit) @(negedge clk);
    end
    w0 = wb_cnt;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (!hit || {stall, dmem_req, out_valid, out_we, out_rd, out_result} !== '0) begin
      n_err++;
      $display("FAIL rst_mid: got hit=%b stall=%b req=%b v=%b we=%b, want hit=1 rest 0",
               hit, stall, dmem_req, out_valid, out_we);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    n_cmp++;
    if (wb_cnt != w0 || stall !== 1'b0) begin
      n_err++;
      $display("FAIL rst_late_rvalid: got %0d WB, stall=%b, want 0 WB stall=0",
               wb_cnt - w0, stall);
    end
  endtask

  task automatic test_misalign();
    int c0 = req_cnt;
    int m0 = mis_cnt;
    ready_dly = 0; rv_dly = 1; rd_word = 32'hCAFE_F00D;
`ifdef LSU_MISALIGN_TRAP_EN
    sb.push_back('{4'd10, 1'b0, 32'h0, "lw_trap"});
    drive(4'd3, 32'h0000_0101, 32'h0, 4'd10, 1'b1);
    wait_drain();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (mis_cnt - m0 != 1 || req_cnt != c0) begin
      n_err++;
      $display("FAIL lw_trap: got %0d misalign pulses %0d reqs, want 1 and 0",
               mis_cnt - m0, req_cnt - c0);
    end
`else
    sb.push_back('{4'd10, 1'b1, 32'hCAFE_F00D, "lw_round"});
    drive(4'd3, 32'h0000_0101, 32'h0, 4'd10, 1'b1);
    wait_drain();
    n_cmp++;
    if (mis_cnt != m0 || req_cnt != c0 + 1 ||
        {lg_addr, lg_wstrb} !== {10'h040, 4'hF}) begin
      n_err++;
      $display("FAIL lw_round: got mis=%0d n=%0d a=%h s=%h, want mis=0 n=1 a=040 s=f",
               mis_cnt - m0, req_cnt - c0, lg_addr, lg_wstrb);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_passthru();
    test_bubble();
    test_stores();
    test_load_lb();
    test_load_misc();
    test_back_to_back();
    test_rst_mid();
    test_misalign();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL final_drain: got %0d pending, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit filling the two memory stages (MEMPREP, MEMEX) between EX and WB of the RV32E core.
- Takes the EX result (address or ALU value) plus store data, and drives a valid/ready data-memory port.
- Formats byte/half/word load data and hands rd, result and we to the WB boundary.
- Stalls upstream while a memory transaction is outstanding.

Parameters:
- ADDR_W, 12: byte address width into data memory; the word address is ADDR_W-2 bits.
- XLEN, 32: datapath width.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  EX result valid
- in_rd  in  4  destination register
- in_we  in  1  regfile write enable
- in_mem_op  in  4  0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 9 SB, 10 SH, 11 SW; other codes = none
- in_addr  in  XLEN  ALU result: effective address for mem ops, pass-through value otherwise
- in_store_data  in  XLEN  rs2 data
- stall  out  1  upstream hold
- dmem_req  out  1  request valid
- dmem_we  out  1  1 = store
- dmem_addr  out  ADDR_W-2  word address
- dmem_wstrb  out  4  byte strobes
- dmem_wdata  out  XLEN  lane-replicated store data
- dmem_ready  in  1  request accepted
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  XLEN  load word
- out_valid  out  1  WB valid
- out_rd  out  4  WB rd
- out_result  out  XLEN  WB data
- out_we  out  1  WB regfile write enable
- misalign  out  1  misaligned access flag, one-cycle pulse

Behaviour:
- Reset: every output is 0, both stage registers are invalid, FSM is IDLE.
- MEMPREP register:
  - Captures inputs when stall=0; holds when stall=1.
  - Computes off=addr[1:0].
  - wstrb: SB = 1<<off, SH = 3<<off, SW = 4'hF.
  - wdata: SB replicates byte x4, SH replicates half x2, SW passes the word.
- MEMEX FSM states:
  - IDLE: accepts MEMPREP contents when MEMPREP is valid.
    - Non-mem op: registers to WB next cycle. out_result=addr, out_we=in_we. Total latency 3 cycles from in_valid.
    - Mem op: goes to REQ.
  - REQ: dmem_req=1 with stable addr/we/wstrb/wdata until dmem_ready.
    - On store accept: WB gets out_valid=1, out_we=0; FSM returns to IDLE.
    - On load accept: goes to RESP.
  - RESP: waits for dmem_rvalid, then extracts the byte/half at off.
    - Sign-extend for LB/LH, zero-extend for LBU/LHU.
    - WB gets out_we=1; FSM returns to IDLE.
- stall = (state != IDLE) or (MEMEX holds an unfinished mem op). MEMPREP and in_* are frozen while stall=1.
- While stalled, out_valid=0 (bubble); no WB output is repeated.
- dmem_rvalid is legal no earlier than the cycle after dmem_ready and is ignored outside RESP.
- in_valid=0 or in_we=0 with a non-mem op: passes through as a bubble, out_valid=0.
- Reset mid-transaction: FSM returns to IDLE immediately, dmem_req drops, and a late rvalid is ignored.
- Address bits above ADDR_W are ignored.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: LH/LHU/SH with off[0]=1, or LW/SW with off!=0, issues no dmem_req. misalign pulses 1 cycle. WB gets out_valid=1, out_we=0; no stall is incurred.
- Undefined: misalign is tied 0. Low address bits are forced to natural alignment (half: off&2, word: 0) and the access proceeds.

Test Plan:
- Non-mem op, addr=0x0000_1234, rd=5, we=1 -> 3 cycles later out_valid=1, out_rd=5, out_result=0x1234; dmem_req never asserted.
- SB addr=0x102, data=0xAB, dmem_ready=1 -> dmem_addr=0x40, wstrb=4'b0100, wdata=0xABABABAB; WB out_we=0.
- LB addr=0x103, rdata=0x80FF_0000, ready after 2 cycles, rvalid 1 cycle later -> out_result=0xFFFF_FF80, stall high for the whole wait.
- LHU addr=0x002, rdata=0x8001_1234 -> out_result=0x0000_8001. Same access as LH -> 0xFFFF_8001.
- Assert rst low while in RESP, then raise rvalid -> all outputs 0, no WB write, FSM IDLE.
- LW addr=0x101 -> with LSU_MISALIGN_TRAP_EN: misalign=1, no req, out_we=0. Without it: request to word 0x40 with wstrb 4'hF.
